// File: rtl/mul_hilo_pkg.sv
// Shared op encoding, FSM states and default multiplier latency for the HI/LO sequencer.
package mul_hilo_pkg;

    localparam int unsigned MulCycleDefault = 5;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpMthi  = 3'b010,
        OpMtlo  = 3'b011,
        OpMadd  = 3'b100,
        OpMaddu = 3'b101,
        OpMsub  = 3'b110,
        OpMsubu = 3'b111
    } hilo_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAcc,
        StDone
    } mul_hilo_state_e;

endpackage

// File: rtl/hilo_acc.sv
// Combinational HI/LO accumulate: sum = hilo +/- prod, carry/borrow out of the top bit dropped.
// Present only when MUL_HILO_ACC_EN is defined.
`ifdef MUL_HILO_ACC_EN
module hilo_acc #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] hilo,
    input  logic [W-1:0] prod,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = sub ? (hilo - prod) : (hilo + prod);

endmodule
`endif

// File: rtl/mul_hilo_ctrl.sv
// HI/LO owner and sequencer for the pipelined multiplier; stalls EX while a multiply is in flight.
// Define MUL_HILO_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module mul_hilo_ctrl
    import mul_hilo_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_CYCLE = MulCycleDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_type,
    input  logic [DATA_W-1:0] op_src1,
    input  logic [DATA_W-1:0] op_src2,
    input  logic              flush,
    output logic              stall_o,
    output logic              mul_permit,
    output logic              mul_sign,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic              mul_finish,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              mul_err_o
);

    localparam int unsigned HiloW   = 2 * DATA_W;
    localparam int unsigned WdLimit = 2 * MUL_CYCLE;
    localparam int unsigned WdW     = $clog2(WdLimit + 1);

    mul_hilo_state_e   state_q, state_d;
    hilo_op_e          op;
    logic              is_mt, mt_hi, is_mul, accept;
    logic [DATA_W-1:0] hi_q, lo_q, src1_q, src2_q;
    logic              sign_q, err_q;
    logic [WdW-1:0]    wd_q;
    logic              wd_tick, wd_fire;
    logic              hilo_we;
    logic [HiloW-1:0]  hilo_d;
    logic              acc_flag;

`ifdef MUL_HILO_ACC_EN
    logic             acc_q, sub_q;
    logic [HiloW-1:0] prod_q, acc_sum;

    assign acc_flag = acc_q;

    hilo_acc #(
        .W(HiloW)
    ) u_hilo_acc (
        .hilo({hi_q, lo_q}),
        .prod(prod_q),
        .sub (sub_q),
        .sum (acc_sum)
    );
`else
    assign acc_flag = 1'b0;
`endif

    // Without accumulation, 11x aliases onto MTHI/MTLO and 10x onto MULT/MULTU.
    assign op = hilo_op_e'(op_type);
    always_comb begin
        is_mt = 1'b0;
        mt_hi = 1'b0;
        unique case (op)
            OpMthi: begin is_mt = 1'b1; mt_hi = 1'b1; end
            OpMtlo: is_mt = 1'b1;
`ifndef MUL_HILO_ACC_EN
            OpMsub:  begin is_mt = 1'b1; mt_hi = 1'b1; end
            OpMsubu: is_mt = 1'b1;
`endif
            default: ;
        endcase
    end

    assign is_mul  = ~is_mt;
    assign accept  = (state_q == StIdle) && op_valid && is_mul && !flush;
    assign wd_tick = (state_q == StMul) && !mul_finish && !flush && (wd_q != WdW'(WdLimit));
    assign wd_fire = wd_tick && (wd_q == WdW'(WdLimit - 1));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (op_valid && is_mul) state_d = StMul;
                StMul:   if (mul_finish) state_d = acc_flag ? StAcc : StDone;
                StAcc:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        hilo_we = 1'b0;
        hilo_d  = {hi_q, lo_q};
        if (!flush) begin
            unique case (state_q)
                StIdle: begin
                    stall_o = op_valid && is_mul;
                    if (op_valid && is_mt) begin
                        hilo_we = 1'b1;
                        if (mt_hi) hilo_d[HiloW-1:DATA_W] = op_src1;
                        else       hilo_d[DATA_W-1:0]     = op_src1;
                    end
                end
                StMul: begin
                    stall_o = 1'b1;
                    if (mul_finish && !acc_flag) begin
                        hilo_we = 1'b1;
                        hilo_d  = {mul_hi, mul_lo};
                    end
                end
                StAcc: begin
                    stall_o = 1'b1;
`ifdef MUL_HILO_ACC_EN
                    hilo_we = 1'b1;
                    hilo_d  = acc_sum;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mul_permit = (state_q == StMul);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            sign_q <= 1'b0;
            wd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (hilo_we) {hi_q, lo_q} <= hilo_d;
            if (accept) begin
                src1_q <= op_src1;
                src2_q <= op_src2;
                sign_q <= ~op_type[0];
                wd_q   <= '0;
            end else if (wd_tick) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_fire) err_q <= 1'b1;
        end
    end

`ifdef MUL_HILO_ACC_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
            prod_q <= '0;
        end else begin
            if (accept) begin
                acc_q <= op_type[2];
                sub_q <= op_type[2] & op_type[1];
            end
            // Product is only valid while permit is high, so grab it on the finish edge.
            if ((state_q == StMul) && mul_finish && !flush) prod_q <= {mul_hi, mul_lo};
        end
    end
`endif

    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign mul_src1  = src1_q;
    assign mul_src2  = src2_q;
    assign mul_sign  = sign_q;
    assign mul_err_o = err_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl with a behavioural multiplier and an arithmetic HI/LO model.
module tb_mul_hilo_ctrl;
    import mul_hilo_pkg::*;

`ifdef MUL_HILO_ACC_EN
    localparam bit AccEn = 1'b1;
`else
    localparam bit AccEn = 1'b0;
`endif

    logic        clk, rst, op_valid, flush;
    logic [2:0]  op_type;
    logic [31:0] op_src1, op_src2;
    logic        stall_o, mul_permit, mul_sign, mul_finish, mul_err_o;
    logic [31:0] mul_src1, mul_src2, mul_hi, mul_lo, hi_o, lo_o;

    mul_hilo_ctrl #(
        .DATA_W   (32),
        .MUL_CYCLE(MulCycleDefault)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_type   (op_type),
        .op_src1   (op_src1),
        .op_src2   (op_src2),
        .flush     (flush),
        .stall_o   (stall_o),
        .mul_permit(mul_permit),
        .mul_sign  (mul_sign),
        .mul_src1  (mul_src1),
        .mul_src2  (mul_src2),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo),
        .mul_finish(mul_finish),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .mul_err_o (mul_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Multiplier stand-in: finish after MUL_CYCLE edges of held permit, garbage when idle.
    int unsigned pcnt = 0;
    bit          fin_en = 1'b1;
    logic [63:0] prod;
    always @(posedge clk) begin
        if (!mul_permit) pcnt <= 0;
        else if (pcnt < MulCycleDefault) pcnt <= pcnt + 1;
    end
    assign mul_finish = fin_en && mul_permit && (pcnt == MulCycleDefault);
    always_comb begin
        if (mul_sign) prod = longint'($signed(mul_src1)) * longint'($signed(mul_src2));
        else          prod = {32'b0, mul_src1} * {32'b0, mul_src2};
        if (!mul_permit) prod = 64'hDEAD_BEEF_0BAD_F00D;
    end
    assign mul_hi = prod[63:32];
    assign mul_lo = prod[31:0];

    typedef struct {
        logic [63:0] hilo;
        int          stall;
        bit          is_mul;
        logic        sign;
        logic [31:0] a, b;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_hilo = '0;
    bit          mon_quiet = 1'b1;

    task automatic model_push(input logic [2:0] t_in, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [2:0]  t;
        logic [63:0] p;
        t = t_in;
        if (!AccEn) t[2] = 1'b0;
        e.a = a;
        e.b = b;
        e.sign = ~t[0];
        if (t == 3'b010) begin
            m_hilo[63:32] = a;
            e.stall = 0;
            e.is_mul = 1'b0;
        end else if (t == 3'b011) begin
            m_hilo[31:0] = a;
            e.stall = 0;
            e.is_mul = 1'b0;
        end else begin
            if (t[0]) p = {32'b0, a} * {32'b0, b};
            else      p = longint'($signed(a)) * longint'($signed(b));
            if (!t[2])     m_hilo = p;
            else if (t[1]) m_hilo = m_hilo - p;
            else           m_hilo = m_hilo + p;
            e.stall = t[2] ? MulCycleDefault + 3 : MulCycleDefault + 2;
            e.is_mul = 1'b1;
        end
        e.hilo = m_hilo;
        exp_q.push_back(e);
    endtask

    // Called right after a negedge; returns at the negedge following retirement.
    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        model_push(t, a, b);
        op_valid = 1'b1;
        op_type  = t;
        op_src1  = a;
        op_src2  = b;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (!stall_o) done = 1'b1;
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk("retire", 64'(done), 64'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hi"}, 64'(hi_o), 64'd0);
        chk({tag, "_lo"}, 64'(lo_o), 64'd0);
        chk({tag, "_src1"}, 64'(mul_src1), 64'd0);
        chk({tag, "_src2"}, 64'(mul_src2), 64'd0);
        chk({tag, "_sign"}, 64'(mul_sign), 64'd0);
        chk({tag, "_err"}, 64'(mul_err_o), 64'd0);
        chk({tag, "_permit"}, 64'(mul_permit), 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: checks HI/LO and stall length the cycle after each retirement, operands at permit rise.
    initial begin
        exp_t e;
        bit   pend = 1'b0;
        bit   prev_permit = 1'b0;
        int   run = 0;
        int   saved = 0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_quiet || !rst) begin
                pend = 1'b0;
                run = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hilo", {hi_o, lo_o}, e.hilo);
                        chk("stall_len", 64'(saved), 64'(e.stall));
                    end
                end
                if (mul_permit && !prev_permit) begin
                    if (exp_q.size() == 0) begin
                        chk("permit_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("permit_for_mul", 64'(exp_q[0].is_mul), 64'd1);
                        chk("mul_sign", 64'(mul_sign), 64'(exp_q[0].sign));
                        chk("mul_src1", 64'(mul_src1), 64'(exp_q[0].a));
                        chk("mul_src2", 64'(mul_src2), 64'(exp_q[0].b));
                    end
                end
                if (mul_permit) chk("sign_held", 64'(mul_sign), 64'(exp_q.size() ? exp_q[0].sign : 1'bx));
                if (op_valid && !flush && !stall_o) begin
                    pend = 1'b1;
                    saved = run;
                    run = 0;
                end else if (stall_o) begin
                    run++;
                end
            end
            prev_permit = mul_permit;
        end
    end

    initial begin
        rst = 1'b0;
        op_valid = 1'b0;
        op_type = '0;
        op_src1 = '0;
        op_src2 = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset("rst");
        rst = 1'b1;
        mon_quiet = 1'b0;
        @(negedge clk);

        issue(OpMultu, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(OpMult, 32'hFFFF_FFFF, 32'h0000_0003);
        issue(OpMthi, 32'h1234_5678, 32'h0);
        issue(OpMtlo, 32'h9ABC_DEF0, 32'h0);
        issue(OpMthi, 32'h0000_0000, 32'h0);
        issue(OpMtlo, 32'hFFFF_FFFF, 32'h0);
        issue(OpMaddu, 32'h1, 32'h1);
        issue(OpMsub, 32'h1, 32'h2);
        repeat (2) @(negedge clk);

        // Flush in MUL cycle 3: abandon without touching HI/LO.
        mon_quiet = 1'b1;
        op_valid = 1'b1;
        op_type = OpMult;
        op_src1 = 32'h0000_1234;
        op_src2 = 32'h0000_5678;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_stall_low", 64'(stall_o), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b0;
        #1 chk("flush_permit", 64'(mul_permit), 64'd0);
        chk("flush_hilo", {hi_o, lo_o}, m_hilo);

        // Flush coincident with the finish cycle.
        @(negedge clk);
        op_valid = 1'b1;
        op_type = OpMultu;
        op_src1 = 32'hCAFE_0001;
        op_src2 = 32'h0000_0010;
        repeat (6) @(negedge clk);
        #1 chk("coinc_finish", 64'(mul_finish), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b0;
        #1 chk("coinc_permit", 64'(mul_permit), 64'd0);
        @(negedge clk);
        #1 chk("coinc_hilo", {hi_o, lo_o}, m_hilo);

        // Flushed move-to must not write.
        op_valid = 1'b1;
        op_type = OpMthi;
        op_src1 = 32'h5555_AAAA;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b0;
        #1 chk("flush_mt_hilo", {hi_o, lo_o}, m_hilo);
        @(negedge clk);
        mon_quiet = 1'b0;

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Watchdog: multiplier never finishes.
        mon_quiet = 1'b1;
        fin_en = 1'b0;
        op_valid = 1'b1;
        op_type = OpMult;
        op_src1 = 32'h7;
        op_src2 = 32'h9;
        repeat (10) @(negedge clk);
        #1 chk("wd_early", 64'(mul_err_o), 64'd0);
        @(negedge clk);
        #1 chk("wd_set", 64'(mul_err_o), 64'd1);
        chk("wd_stays_mul", 64'(mul_permit), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b0;
        fin_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("wd_sticky", 64'(mul_err_o), 64'd1);
        chk("wd_hilo", {hi_o, lo_o}, m_hilo);
        rst = 1'b0;
        @(negedge clk);
        #1 chk_reset("wdrst");
        rst = 1'b1;
        m_hilo = '0;

        // Set HI/LO, then reset in the middle of a multiply.
        @(negedge clk);
        mon_quiet = 1'b0;
        issue(OpMult, 32'h8000_0000, 32'h0000_0003);
        repeat (2) @(negedge clk);
        mon_quiet = 1'b1;
        op_valid = 1'b1;
        op_type = OpMultu;
        op_src1 = 32'hFFFF_0000;
        op_src2 = 32'h0001_0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        #1 chk_reset("midrst");
        rst = 1'b1;
        m_hilo = '0;
        @(negedge clk);
        mon_quiet = 1'b0;

        issue(OpMaddu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OpMultu, 32'h0000_0003, 32'h0000_0005);
        issue(OpMsubu, 32'h0000_0010, 32'h0000_0001);
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencer and HI/LO owner for the pipelined multiplier IP pair. Sits in EX beside the multiplier. Accepts multiply and move-to-HI/LO ops from the EX stage, drives the multiplier's `permit`/`sign`/operand inputs, and captures the 64-bit product. Optionally accumulates the product into HI/LO, holds the pipeline with `stall_o`, and discards in-flight work on an exception flush.

## Interface
- `DATA_W`, 32: operand and HI/LO width. Only 32 is supported.
- `MUL_CYCLE`, 5: nominal multiplier latency in edges of held `permit`. Used by the watchdog.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `op_valid` in 1: EX holds a HI/LO-class op.
- `op_type` in 3:
  - 000 MULT, 001 MULTU, 010 MTHI, 011 MTLO
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- `op_src1`, `op_src2` in 32: rs/rt values. MTHI/MTLO use `op_src1`.
- `flush` in 1: exception/ERET flush from MEM/WB.
- `stall_o` out 1: hold EX and everything upstream.
- `mul_permit` out 1: to multiplier `permit_mult`.
- `mul_sign` out 1: to multiplier `mult_sign`.
- `mul_src1`, `mul_src2` out 32: latched operands to the multiplier.
- `mul_hi`, `mul_lo` in 32: multiplier product. Valid only while `mul_permit`=1.
- `mul_finish` in 1: multiplier `finish_mult`.
- `hi_o`, `lo_o` out 32: architectural HI/LO.
- `mul_err_o` out 1: sticky watchdog error.

## Operation
- **States:** IDLE, MUL, ACC, DONE.
- **IDLE:**
  - `op_valid` & MTHI/MTLO & !`flush`: write `hi_o`/`lo_o` at the edge. No stall. Stay in IDLE.
  - `op_valid` & multiply-class & !`flush`: latch operands, latch sign (`op_type[0]`=0 means signed), latch accumulate flag (`op_type[2]`) and subtract flag (`op_type[1]`&`op_type[2]`). Go to MUL.
- **MUL:**
  - `mul_permit`=1.
  - On `mul_finish`=1, capture `{mul_hi,mul_lo}` at that edge; capture is required while permit is still high.
  - Non-accumulate: write HI/LO and go to DONE.
  - Accumulate: store the product and go to ACC.
- **ACC:** `{HI,LO} <= {HI,LO} ± product`, 64-bit modular; the carry out of bit 63 is dropped. Go to DONE.
- **DONE:** `stall_o`=0 for one cycle so the instruction leaves EX. `op_valid` is ignored here. Next state is IDLE.
- **`stall_o`:**
  - Combinational 1 in IDLE when `op_valid` & multiply-class & !`flush`.
  - 1 throughout MUL and ACC.
  - 0 otherwise.
- **`flush`:** highest priority in every state.
  - Next state is IDLE.
  - No HI/LO write that cycle, including MTHI/MTLO and a coincident `mul_finish` or ACC.
  - `stall_o`=0 while `flush`=1.
- **Watchdog:** counts MUL cycles. If the count reaches 2×`MUL_CYCLE` without `mul_finish`, set `mul_err_o`; the state stays in MUL. Only reset clears `mul_err_o`.
- **Back-to-back ops:** a new multiply-class op in IDLE right after DONE is accepted normally. The multiplier counter self-clears when permit drops in DONE.

## Timing
- **Reset:**
  - State IDLE.
  - `hi_o`=`lo_o`=0, `mul_src1`=`mul_src2`=0, `mul_sign`=0, `mul_err_o`=0.
  - `mul_permit`=0 and `stall_o`=0.
- **Reset mid-operation:** same as reset; the product is discarded.
- **MULT/MULTU timeline:** accept edge at cycle 0 → MUL cycles 1..6. `mul_finish` rises in cycle 6 after 5 permit edges. Capture at the end of cycle 6. DONE in cycle 7, with new HI/LO visible in cycle 7. `stall_o` is high for cycles 0–6, i.e. `MUL_CYCLE`+2 cycles.
- **MADD/MSUB timeline:** ACC in cycle 7, DONE in cycle 8. `stall_o` is high for `MUL_CYCLE`+3 cycles.
- **MTHI/MTLO:** value visible on `hi_o`/`lo_o` the cycle after `op_valid`.
- **Forwarding:** `hi_o`/`lo_o` are registered only. There is no forwarding of same-cycle writes.

## Configuration
- **`MUL_HILO_ACC_EN` defined:** MADD/MADDU/MSUB/MSUBU execute as above.
- **`MUL_HILO_ACC_EN` undefined:**
  - The ACC state and adder are absent.
  - Op types 1xx behave as their 0xx counterparts: 100→MULT, 101→MULTU, 110→MTHI, 111→MTLO.
  - Accumulate flags are tied to 0.

## Structure
- **Shared package `mul_hilo_pkg`:**
  - `hilo_op_e` op encoding.
  - `mul_hilo_state_e` state enum.
  - `MUL_CYCLE` default constant.
- **Sub-module `hilo_acc`:** combinational 64-bit add/sub, `{hi,lo} ± p`, with a `sub` select. Compiled only under `MUL_HILO_ACC_EN`.

## Test plan
- **Unsigned multiply:** reset, then MULTU `0xFFFFFFFF`×`0x00000002` → `stall_o` high 7 cycles; `hi_o`=`0x00000001`, `lo_o`=`0xFFFFFFFE` in DONE.
- **Signed multiply:** MULT `0xFFFFFFFF`(−1)×`0x00000003` → `hi_o`=`0xFFFFFFFF`, `lo_o`=`0xFFFFFFFD`; `mul_sign`=1 throughout MUL.
- **Move-to:** MTHI `0x12345678` then MTLO `0x9ABCDEF0` on consecutive cycles → no stall; `hi_o`/`lo_o` update the following cycles.
- **Accumulate (ACC_EN):** HI:LO=`0x00000000_FFFFFFFF`, MADDU 1×1 → `0x00000001_00000000`. Then MSUB 1×2 → `0x00000000_FFFFFFFE`. `stall_o` high 8 cycles each.
- **Flush:** assert `flush` in MUL cycle 3 → state IDLE next cycle, `mul_permit`=0, HI/LO unchanged. Assert `flush` coincident with `mul_finish` → no write.
- **Watchdog:** tie `mul_finish`=0 during a MULT → `mul_err_o` rises after 10 MUL cycles and stays high until `rst`=0.
